// File: rtl/joy_shift_responder.sv
// joy_shift_responder: pad-side model of a 74HC165 shift register fed by a
// Sega 3/6-button pad. The reader's pl/cp/sel lines are sampled into the clk
// domain. The register contents come from the pad lines that the current
// select phase exposes.
module joy_shift_responder #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 37500,
    parameter int TCW            = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pl,
    input  logic        cp,
    input  logic        sel,
    input  logic        six_button_en,
    input  logic [11:0] pad_n,
    output logic        q
);

    localparam logic [TCW-1:0] TO_MAX = TCW'(TIMEOUT_CYCLES);
    localparam logic [TCW-1:0] TO_PRE = TCW'(TIMEOUT_CYCLES - 1);

    // Synchroniser stages (m = first, s = second) plus edge-detect delay flops
    logic pl_m, pl_s;
    logic cp_m, cp_s, cp_d;
    logic sel_m, sel_s, sel_d;

    logic cp_rise_r;
    logic sel_fall;
    logic sel_edge;
    logic timeout_hit;

    logic [TCW-1:0]   to_cnt;
    logic [2:0]       low_cnt;
    logic [5:0]       lines;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] sr;

    // Pad button aliases (active low)
    logic b_up, b_down, b_left, b_right, b_b, b_c, b_a, b_start;
    logic b_z, b_y, b_x, b_mode;

    assign b_up    = pad_n[0];
    assign b_down  = pad_n[1];
    assign b_left  = pad_n[2];
    assign b_right = pad_n[3];
    assign b_b     = pad_n[4];
    assign b_c     = pad_n[5];
    assign b_a     = pad_n[6];
    assign b_start = pad_n[7];
    assign b_z     = pad_n[8];
    assign b_y     = pad_n[9];
    assign b_x     = pad_n[10];
    assign b_mode  = pad_n[11];

    // Two-flop synchronisers with an extra delay stage for cp/sel edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            pl_m  <= 1'b1;
            pl_s  <= 1'b1;
            cp_m  <= 1'b0;
            cp_s  <= 1'b0;
            cp_d  <= 1'b0;
            sel_m <= 1'b1;
            sel_s <= 1'b1;
            sel_d <= 1'b1;
        end else begin
            pl_m  <= pl;
            pl_s  <= pl_m;
            cp_m  <= cp;
            cp_s  <= cp_m;
            cp_d  <= cp_s;
            sel_m <= sel;
            sel_s <= sel_m;
            sel_d <= sel_s;
        end
    end

    // Registered cp rising-edge pulse; the extra stage gives the 5-clk cp-to-q latency
    always_ff @(posedge clk) begin
        if (rst) begin
            cp_rise_r <= 1'b0;
        end else begin
            cp_rise_r <= cp_s & ~cp_d;
        end
    end

    assign sel_fall    = sel_d & ~sel_s;
    assign sel_edge    = sel_d ^ sel_s;
    // Fires on the cycle the counter reaches the limit and while it stays there
    assign timeout_hit = ~sel_edge & (to_cnt >= TO_PRE);

    // Inactivity counter: cleared by any sel edge, saturating at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (sel_edge) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Select phase counter; a sel edge takes precedence over a coincident timeout
    always_ff @(posedge clk) begin
        if (rst || !six_button_en) begin
            low_cnt <= 3'd0;
        end else if (sel_edge) begin
            if (sel_fall && low_cnt != 3'd4) begin
                low_cnt <= low_cnt + 3'd1;
            end
        end else if (timeout_hit) begin
            low_cnt <= 3'd0;
        end
    end

    // Pad lines {U,D,Lf,R,X5,X4} exposed for the current select level and phase
    always_comb begin
        lines = {b_up, b_down, b_left, b_right, b_b, b_c};
        if (sel_s) begin
            if (six_button_en && low_cnt == 3'd3) begin
                lines = {b_z, b_y, b_x, b_mode, b_b, b_c};
            end
        end else begin
            if (six_button_en && low_cnt == 3'd3) begin
                lines = {4'b0000, b_a, b_start};
            end else if (six_button_en && low_cnt == 3'd4) begin
                lines = {4'b1111, b_a, b_start};
            end else begin
                lines = {b_up, b_down, 2'b00, b_a, b_start};
            end
        end
    end

    // Parallel-load word: pad lines in the top six bits, pull-ups below
    always_comb begin
        load_word = '1;
        load_word[WIDTH-1 -: 6] = lines;
    end

    // Shift register: level-sensitive load wins over shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '1;
        end else if (!pl_s) begin
            sr <= load_word;
        end else if (cp_rise_r) begin
            sr <= {sr[WIDTH-2:0], 1'b1};
        end
    end

    // Registered serial output
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b1;
        end else begin
            q <= sr[WIDTH-1];
        end
    end

endmodule
